// File: rtl/reg_file.sv
// reg_file: 2^ADDR_W x N_bit register file for the single-cycle MIPS datapath.
// Two combinational read ports (rs -> SrcA, rt -> SrcB/store data), one debug
// read port and one synchronous write port. Register 0 is hardwired to zero.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, reads that match an
// active write address return WD3 in the same cycle (write-first). Otherwise,
// reads always return stored contents (read-before-write).
module reg_file #(
  parameter int unsigned N_bit  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [N_bit-1:0]  WD3,
  output logic [N_bit-1:0]  RD1,
  output logic [N_bit-1:0]  RD2,
  input  logic [ADDR_W-1:0] DbgA,
  output logic [N_bit-1:0]  DbgRD
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [N_bit-1:0] regs_q [Depth];
  logic [N_bit-1:0] regs_d [Depth];

  // Writes to address 0 are dropped here so R[0] can never hold a value.
  logic wr_en;
  assign wr_en = WE3 && (A3 != '0);

  // Next-state: copy current contents, overlay the single write.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[A3] = WD3;
    end
    regs_d[0] = '0;
  end

  // Storage; asynchronous reset clears everything, so a write on an edge
  // that coincides with reset is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [N_bit-1:0] rd1_raw, rd2_raw, dbg_raw;

  // Stored-content reads; address 0 forced to zero regardless of history.
  always_comb begin
    rd1_raw = (A1 == '0)   ? '0 : regs_q[A1];
    rd2_raw = (A2 == '0)   ? '0 : regs_q[A2];
    dbg_raw = (DbgA == '0) ? '0 : regs_q[DbgA];
  end

`ifdef REGFILE_BYPASS_EN
  // Bypass is gated by rst_n so all ports still read 0 during reset.
  logic byp_en;
  assign byp_en = wr_en && rst_n;

  // Write-first read ports: forward WD3 to any port matching A3.
  always_comb begin
    RD1   = (byp_en && (A1 == A3))   ? WD3 : rd1_raw;
    RD2   = (byp_en && (A2 == A3))   ? WD3 : rd2_raw;
    DbgRD = (byp_en && (DbgA == A3)) ? WD3 : dbg_raw;
  end
`else
  // Read-before-write ports: the write is only visible after the edge.
  always_comb begin
    RD1   = rd1_raw;
    RD2   = rd2_raw;
    DbgRD = dbg_raw;
  end
`endif

endmodule
